fc_readout_ctrl: RTL and testbench
==================================

Name: fc_readout_ctrl

Overview:
- Capture and readout controller for the frequency-counter datapath.
- On every counter-ready pulse, latches the three counter results plus a sequence tag into a small FIFO.
- Exposes the FIFO, status and control to the CPU through the iomem bus slave interface.
- Decouples measurement cadence from firmware polling latency, so samples are queued instead of overwritten, and drops are counted.

Parameters:
- SIG_BITS, 32, width of the signal edge count.
- SYS_BITS, 32, width of the system-clock counts.
- DEPTH_LOG2, 2, FIFO depth = 2**DEPTH_LOG2 entries.
- EPOCH_BITS, 8, width of the per-sample sequence tag.
- BASE_HI, 8'h03, required value of iomem_addr[31:24].

Ports:
- clk  in  1  system clock; all logic on posedge.
- resetn  in  1  synchronous active-low reset.
- fc_ready  in  1  one-cycle pulse: counter results valid this cycle.
- fc_ref_sys_cnt  in  SYS_BITS  sys-clock count over the reference gate.
- fc_sig_cnt  in  SIG_BITS  signal edge count.
- fc_sig_sys_cnt  in  SYS_BITS  sys-clock count over the signal gate.
- iomem_valid  in  1  bus request.
- iomem_ready  out  1  one-cycle acknowledge.
- iomem_wstrb  in  4  byte write strobes; 0 = read.
- iomem_addr  in  32  byte address.
- iomem_wdata  in  32  write data.
- iomem_rdata  out  32  read data; valid when iomem_ready=1.
- irq  out  1  level interrupt.

Behaviour:
- Reset (resetn=0 at posedge):
  - FIFO empty; level=0; epoch=0; drop_cnt=0.
  - CTRL.en=1, CTRL.irq_en=0.
  - iomem_ready=0, iomem_rdata=0, irq=0.
- Address decode:
  - A transaction is claimed when iomem_valid && !iomem_ready && addr[31:24]==BASE_HI && addr[7:0] is in the map below.
  - Unmapped offsets are not claimed; iomem_ready stays 0.
  - Claimed transaction: iomem_ready=1 on the next posedge for exactly one cycle; rdata is registered at the same edge.
- Register map (offset, fields):
  - 0x20 STATUS (RO): [DEPTH_LOG2:0] level; [16] empty; [17] full; [31:24] drop_cnt.
  - 0x24 CTRL (RW, byte 0 only): [0] en; [1] irq_en; [2] flush (write-1 pulse, reads 0).
  - 0x28 HEAD_REF (RO): head ref_sys_cnt.
  - 0x2C HEAD_SIG (RO): head sig_cnt.
  - 0x30 HEAD_SIGSYS (RO): head sig_sys_cnt.
  - 0x34 HEAD_EPOCH_POP (RO): [EPOCH_BITS-1:0] head epoch tag; [31] valid. A claimed read when non-empty pops the head.
- Data field widths: fields narrower than 32 bits are zero-extended.
- Writes: writes to RO offsets are acknowledged and ignored.
- Empty FIFO reads: HEAD reads return 0 and do not pop.
- Epoch: increments (mod 2**EPOCH_BITS) on every fc_ready, whether or not the sample is stored. Each stored entry carries the pre-increment value, so gaps reveal drops.
- Push: fc_ready && en && !full (or full with a simultaneous pop) stores {ref, sig, sigsys, epoch}.
- Drop: fc_ready && en && full && no pop. drop_cnt increments, saturating at 255.
  - fc_ready with en=0: no push, no drop count, epoch still increments.
- Simultaneous push + pop:
  - Pop takes the old head and push appends; level unchanged.
  - Valid at every level. At empty, no pop occurs, so it is a plain push.
- Pop timing: the pop takes effect at the iomem_ready edge. The next transaction sees the new head.
- Flush (CTRL write, wstrb[0] && wdata[2]):
  - At that edge: level=0, drop_cnt=0; epoch is not cleared.
  - An fc_ready in the same cycle is discarded and not counted as a drop; epoch still increments.
  - en and irq_en update from the same write.
- irq: registered; irq = irq_en && level!=0, evaluated on next-state values.
- Pointers: read/write pointers are DEPTH_LOG2 bits and wrap modulo depth. level is DEPTH_LOG2+1 bits.
- Reset mid-transaction: the acknowledge is abandoned; all state returns to reset values.

Test Plan:
- Reset, then 3 fc_ready pulses with (ref,sig,sigsys) = (100,10,101), (200,20,201), (300,30,301) -> STATUS level=3, empty=0; reading 0x28/0x2C/0x30/0x34 gives 100/10/101 then 0x80000000; second set gives epoch 1.
- 6 fc_ready pulses with no reads, DEPTH_LOG2=2 -> level=4, full=1, drop_cnt=2; popped epoch tags are 0,1,2,3; the next fc_ready is stored with tag 6 after one pop.
- FIFO full, pop read lands in the same cycle as fc_ready -> level stays 4, drop_cnt unchanged, new entry appears at the tail.
- Write CTRL=0x06 with level=2, fc_ready pulsed in the same cycle -> level=0, drop_cnt=0, irq_en=1, en=0, irq=0; the next fc_ready stores nothing, and the next stored tag after en=1 shows a gap of 2.
- irq_en=1, single push -> irq rises 1 cycle after fc_ready; pop that entry -> irq falls the cycle after iomem_ready.
- Access to offset 0x38 -> iomem_ready stays 0 for 8 cycles. 300 drops -> drop_cnt reads 255.

Source files
------------

// File: rtl/fc_readout_ctrl.sv
// Capture/readout controller for the frequency counter: queues counter results in a small FIFO
// and exposes the FIFO, status and control through the iomem bus slave.
module fc_readout_ctrl #(
  parameter int unsigned SIG_BITS   = 32,
  parameter int unsigned SYS_BITS   = 32,
  parameter int unsigned DEPTH_LOG2 = 2,
  parameter int unsigned EPOCH_BITS = 8,
  parameter logic [7:0]  BASE_HI    = 8'h03
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                fc_ready,
  input  logic [SYS_BITS-1:0] fc_ref_sys_cnt,
  input  logic [SIG_BITS-1:0] fc_sig_cnt,
  input  logic [SYS_BITS-1:0] fc_sig_sys_cnt,
  input  logic                iomem_valid,
  output logic                iomem_ready,
  input  logic [3:0]          iomem_wstrb,
  input  logic [31:0]         iomem_addr,
  input  logic [31:0]         iomem_wdata,
  output logic [31:0]         iomem_rdata,
  output logic                irq
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam int unsigned LvlW  = DEPTH_LOG2 + 1;

  localparam logic [7:0] OffStatus = 8'h20;
  localparam logic [7:0] OffCtrl   = 8'h24;
  localparam logic [7:0] OffRef    = 8'h28;
  localparam logic [7:0] OffSig    = 8'h2C;
  localparam logic [7:0] OffSigSys = 8'h30;
  localparam logic [7:0] OffPop    = 8'h34;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [LvlW-1:0]       lvl_t;

  logic [SYS_BITS-1:0]   ref_mem    [Depth];
  logic [SIG_BITS-1:0]   sig_mem    [Depth];
  logic [SYS_BITS-1:0]   sigsys_mem [Depth];
  logic [EPOCH_BITS-1:0] epoch_mem  [Depth];

  ptr_t                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  lvl_t                  level_q, level_d;
  logic [7:0]            drop_q, drop_d;
  logic [EPOCH_BITS-1:0] epoch_q, epoch_d;
  logic                  en_q, en_d, irq_en_q, irq_en_d, irq_q, irq_d;
  logic                  ready_q;
  logic [31:0]           rdata_q, rdata_d, rd_val;

  logic [7:0] off;
  logic       mapped, claim, is_rd, ctrl_wr, flush, pop, push, drop, empty, full;
  logic       unused_bits;

  assign off         = iomem_addr[7:0];
  assign unused_bits = ^{iomem_addr[23:8], iomem_wdata[31:3]};
  assign mapped      = off inside {OffStatus, OffCtrl, OffRef, OffSig, OffSigSys, OffPop};
  assign claim       = iomem_valid && !ready_q && (iomem_addr[31:24] == BASE_HI) && mapped;
  assign is_rd       = claim && (iomem_wstrb == 4'b0000);
  assign ctrl_wr     = claim && (off == OffCtrl) && iomem_wstrb[0];
  assign flush       = ctrl_wr && iomem_wdata[2];
  assign empty       = (level_q == '0);
  assign full        = (level_q == lvl_t'(Depth));
  assign pop         = is_rd && (off == OffPop) && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the sample.
  assign push        = fc_ready && en_q && !flush && (!full || pop);
  assign drop        = fc_ready && en_q && !flush && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    drop_d   = drop_q;
    epoch_d  = epoch_q;
    en_d     = en_q;
    irq_en_d = irq_en_q;
    if (fc_ready) epoch_d = epoch_q + EPOCH_BITS'(1);
    if (ctrl_wr) begin
      en_d     = iomem_wdata[0];
      irq_en_d = iomem_wdata[1];
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      drop_d   = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + lvl_t'(1);
        2'b01:   level_d = level_q - lvl_t'(1);
        default: level_d = level_q;
      endcase
      if (drop && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
    end
    irq_d = irq_en_d && (level_d != '0);
  end

  always_comb begin
    rd_val = '0;
    case (off)
      OffStatus: begin
        rd_val[LvlW-1:0] = level_q;
        rd_val[16]       = empty;
        rd_val[17]       = full;
        rd_val[31:24]    = drop_q;
      end
      OffCtrl:   rd_val = {30'b0, irq_en_q, en_q};
      OffRef:    if (!empty) rd_val = 32'(ref_mem[rd_ptr_q]);
      OffSig:    if (!empty) rd_val = 32'(sig_mem[rd_ptr_q]);
      OffSigSys: if (!empty) rd_val = 32'(sigsys_mem[rd_ptr_q]);
      OffPop: begin
        if (!empty) begin
          rd_val[EPOCH_BITS-1:0] = epoch_mem[rd_ptr_q];
          rd_val[31]             = 1'b1;
        end
      end
      default:   rd_val = '0;
    endcase
    rdata_d = is_rd ? rd_val : '0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ref_mem[wr_ptr_q]    <= fc_ref_sys_cnt;
      sig_mem[wr_ptr_q]    <= fc_sig_cnt;
      sigsys_mem[wr_ptr_q] <= fc_sig_sys_cnt;
      epoch_mem[wr_ptr_q]  <= epoch_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= '0;
      epoch_q  <= '0;
      en_q     <= 1'b1;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
      ready_q  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      drop_q   <= drop_d;
      epoch_q  <= epoch_d;
      en_q     <= en_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
      ready_q  <= claim;
      rdata_q  <= rdata_d;
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_fc_readout_ctrl.sv
// Self-checking bench for fc_readout_ctrl: directed scenarios plus random traffic checked
// against a queue-based model of the readout FIFO.
module tb_fc_readout_ctrl;

  localparam int Depth = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        fc_ready = 1'b0;
  logic [31:0] fc_ref_sys_cnt = '0, fc_sig_cnt = '0, fc_sig_sys_cnt = '0;
  logic        iomem_valid = 1'b0;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb = '0;
  logic [31:0] iomem_addr = '0, iomem_wdata = '0, iomem_rdata;
  logic        irq;

  always #5 clk = ~clk;

  fc_readout_ctrl dut (
    .clk            (clk),
    .resetn         (resetn),
    .fc_ready       (fc_ready),
    .fc_ref_sys_cnt (fc_ref_sys_cnt),
    .fc_sig_cnt     (fc_sig_cnt),
    .fc_sig_sys_cnt (fc_sig_sys_cnt),
    .iomem_valid    (iomem_valid),
    .iomem_ready    (iomem_ready),
    .iomem_wstrb    (iomem_wstrb),
    .iomem_addr     (iomem_addr),
    .iomem_wdata    (iomem_wdata),
    .iomem_rdata    (iomem_rdata),
    .irq            (irq)
  );

  typedef struct {
    logic [31:0] r;
    logic [31:0] s;
    logic [31:0] ss;
    int          ep;
  } smp_t;

  smp_t mq[$];
  int   m_epoch, m_drop;
  bit   m_en, m_irq_en;
  int   n_checks = 0, n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] m_read(input logic [7:0] off);
    logic [31:0] v;
    v = '0;
    case (off)
      8'h20: begin
        v        = 32'(mq.size());
        v[16]    = (mq.size() == 0);
        v[17]    = (mq.size() == Depth);
        v[31:24] = 8'(m_drop);
      end
      8'h24: v = {30'b0, m_irq_en, m_en};
      8'h28: if (mq.size() > 0) v = mq[0].r;
      8'h2C: if (mq.size() > 0) v = mq[0].s;
      8'h30: if (mq.size() > 0) v = mq[0].ss;
      8'h34: if (mq.size() > 0) v = {1'b1, 23'b0, 8'(mq[0].ep)};
      default: v = '0;
    endcase
    return v;
  endfunction

  // One clock edge of the reference: pop, then sample arrival, then flush/control update.
  task automatic model_edge(input bit fc, input smp_t s, input bit bus, input logic [7:0] off,
                            input logic [3:0] wstrb, input logic [31:0] wdata);
    bit flush, ctrl_wr;
    ctrl_wr = bus && off == 8'h24 && wstrb[0];
    flush   = ctrl_wr && wdata[2];
    if (bus && wstrb == 4'b0 && off == 8'h34 && mq.size() > 0) void'(mq.pop_front());
    if (fc) begin
      s.ep    = m_epoch;
      m_epoch = (m_epoch + 1) % 256;
      if (m_en && !flush) begin
        if (mq.size() < Depth) mq.push_back(s);
        else if (m_drop < 255) m_drop++;
      end
    end
    if (flush) begin
      mq.delete();
      m_drop = 0;
    end
    if (ctrl_wr) begin
      m_en     = wdata[0];
      m_irq_en = wdata[1];
    end
  endtask

  function automatic smp_t rnd_smp();
    smp_t s;
    s.r  = $urandom;
    s.s  = $urandom;
    s.ss = $urandom;
    s.ep = 0;
    return s;
  endfunction

  function automatic smp_t mk_smp(input int r, input int sg, input int ss);
    smp_t s;
    s.r  = 32'(r);
    s.s  = 32'(sg);
    s.ss = 32'(ss);
    s.ep = 0;
    return s;
  endfunction

  task automatic drive_fc(input smp_t s);
    fc_ready       = 1'b1;
    fc_ref_sys_cnt = s.r;
    fc_sig_cnt     = s.s;
    fc_sig_sys_cnt = s.ss;
  endtask

  task automatic pulse(input smp_t s);
    drive_fc(s);
    @(posedge clk); #1;
    fc_ready = 1'b0;
    model_edge(1'b1, s, 1'b0, 8'h00, 4'h0, 32'h0);
    check("irq_after_fc", {31'b0, irq}, {31'b0, m_irq_en && mq.size() != 0});
  endtask

  // Bus transaction, optionally with an fc_ready pulse landing on the claim edge.
  task automatic xfer(input logic [7:0] off, input logic [3:0] wstrb, input logic [31:0] wdata,
                      input bit fc, input smp_t s, output logic [31:0] rdata);
    logic [31:0] exp;
    exp         = m_read(off);
    iomem_valid = 1'b1;
    iomem_addr  = {8'h03, 16'($urandom), off};
    iomem_wstrb = wstrb;
    iomem_wdata = wdata;
    if (fc) drive_fc(s);
    @(posedge clk); #1;
    fc_ready = 1'b0;
    model_edge(fc, s, 1'b1, off, wstrb, wdata);
    check("ack_1cycle", {31'b0, iomem_ready}, 32'd1);
    rdata = iomem_rdata;
    if (wstrb == 4'b0) check($sformatf("rd_%02h", off), rdata, exp);
    iomem_valid = 1'b0;
    iomem_wstrb = '0;
    check("irq_after_bus", {31'b0, irq}, {31'b0, m_irq_en && mq.size() != 0});
    @(posedge clk); #1;
    check("ack_drop", {31'b0, iomem_ready}, 32'd0);
  endtask

  task automatic rd(input logic [7:0] off, output logic [31:0] v);
    smp_t z;
    z = mk_smp(0, 0, 0);
    xfer(off, 4'h0, 32'h0, 1'b0, z, v);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, iomem_ready}, 32'd0);
    check("rst_rdata", iomem_rdata, 32'd0);
    check("rst_irq", {31'b0, irq}, 32'd0);
    resetn = 1'b1;
    mq.delete();
    m_epoch  = 0;
    m_drop   = 0;
    m_en     = 1'b1;
    m_irq_en = 1'b0;
  endtask

  task automatic no_ack(input logic [31:0] addr, input string tag);
    bit seen;
    seen        = 1'b0;
    iomem_valid = 1'b1;
    iomem_addr  = addr;
    iomem_wstrb = 4'h0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (iomem_ready) seen = 1'b1;
    end
    iomem_valid = 1'b0;
    check(tag, {31'b0, seen}, 32'd0);
  endtask

  initial begin
    logic [31:0] v;
    smp_t        z;
    z = mk_smp(0, 0, 0);

    // Reset state and first-sample readout.
    do_reset();
    rd(8'h20, v); check("st_reset", v, 32'h0001_0000);
    rd(8'h24, v); check("ctrl_reset", v, 32'h1);
    pulse(mk_smp(100, 10, 101));
    pulse(mk_smp(200, 20, 201));
    pulse(mk_smp(300, 30, 301));
    rd(8'h20, v); check("st_lvl3", v, 32'h3);
    rd(8'h28, v); check("head_ref", v, 32'd100);
    rd(8'h2C, v); check("head_sig", v, 32'd10);
    rd(8'h30, v); check("head_sigsys", v, 32'd101);
    rd(8'h34, v); check("pop0", v, 32'h8000_0000);
    rd(8'h28, v); check("head_ref2", v, 32'd200);
    rd(8'h34, v); check("pop1", v, 32'h8000_0001);

    // Overflow: 6 samples into 4 slots.
    do_reset();
    for (int i = 0; i < 6; i++) pulse(rnd_smp());
    rd(8'h20, v); check("st_full", v, 32'h0202_0004);
    rd(8'h34, v); check("ovf_tag0", v, 32'h8000_0000);
    pulse(rnd_smp());
    for (int i = 1; i < 4; i++) begin
      rd(8'h34, v); check("ovf_tag", v, 32'h8000_0000 | 32'(i));
    end
    rd(8'h34, v); check("ovf_tag6", v, 32'h8000_0006);
    rd(8'h34, v); check("pop_empty", v, 32'h0);

    // Full FIFO, pop and sample on the same edge.
    do_reset();
    for (int i = 0; i < 4; i++) pulse(rnd_smp());
    xfer(8'h34, 4'h0, 32'h0, 1'b1, rnd_smp(), v);
    check("simul_pop", v, 32'h8000_0000);
    rd(8'h20, v); check("simul_st", v, 32'h0002_0004);
    for (int i = 1; i < 5; i++) begin
      rd(8'h34, v); check("simul_tag", v, 32'h8000_0000 | 32'(i));
    end

    // Flush with a colliding sample, en off, then a tag gap.
    do_reset();
    pulse(rnd_smp());
    pulse(rnd_smp());
    xfer(8'h24, 4'h1, 32'h6, 1'b1, rnd_smp(), v);
    rd(8'h20, v); check("flush_st", v, 32'h0001_0000);
    rd(8'h24, v); check("flush_ctrl", v, 32'h2);
    check("flush_irq", {31'b0, irq}, 32'd0);
    pulse(rnd_smp());
    rd(8'h20, v); check("en0_st", v, 32'h0001_0000);
    xfer(8'h24, 4'h1, 32'h3, 1'b0, z, v);
    pulse(rnd_smp());
    check("irq_rise", {31'b0, irq}, 32'd1);
    rd(8'h34, v); check("gap_tag", v, 32'h8000_0004);
    check("irq_fall", {31'b0, irq}, 32'd0);

    // Unclaimed accesses and drop saturation.
    no_ack(32'h0300_0038, "unmapped_38");
    no_ack(32'h0400_0020, "wrong_base");
    xfer(8'h28, 4'hF, 32'hFFFF_FFFF, 1'b0, z, v);
    for (int i = 0; i < 304; i++) pulse(rnd_smp());
    rd(8'h20, v); check("drop_sat", {24'b0, v[31:24]}, 32'd255);

    // Random traffic.
    do_reset();
    for (int it = 0; it < 400; it++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 3) begin
        pulse(rnd_smp());
      end else if (op <= 6) begin
        logic [7:0] offs [6];
        offs = '{8'h20, 8'h24, 8'h28, 8'h2C, 8'h30, 8'h34};
        xfer(offs[$urandom_range(0, 5)], 4'h0, 32'h0, $urandom_range(0, 2) == 0, rnd_smp(), v);
      end else if (op == 7) begin
        xfer(8'h34, 4'h0, 32'h0, 1'b1, rnd_smp(), v);
      end else if (op == 8) begin
        logic [31:0] wd;
        wd = $urandom & 32'hFFFF_FFF8;
        wd[0] = ($urandom_range(0, 3) != 0);
        wd[1] = $urandom_range(0, 1) == 1;
        wd[2] = ($urandom_range(0, 5) == 0);
        xfer(8'h24, 4'($urandom_range(1, 15)), wd, $urandom_range(0, 1) == 1, rnd_smp(), v);
      end else begin
        xfer(8'h20 + 8'(4 * $urandom_range(2, 5)), 4'hF, $urandom, 1'b0, z, v);
      end
    end

    // Reset during a claimed cycle abandons the acknowledge.
    pulse(rnd_smp());
    iomem_valid = 1'b1;
    iomem_addr  = 32'h0300_0034;
    iomem_wstrb = 4'h0;
    resetn      = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_ack", {31'b0, iomem_ready}, 32'd0);
    iomem_valid = 1'b0;
    do_reset();
    rd(8'h20, v); check("rst_mid_st", v, 32'h0001_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
